quant_writeback: RTL and testbench

- Write-back stage directly downstream of the sticky quantization-done flag.
- When the flag is high, streams N_WORDS quantized results from the quant result buffer (synchronous read) into output memory at a latched base address, honouring a memory ready handshake.
- Then pulses clear back to the flag and returns to idle.

---
 rtl/smac_wb_pkg.sv | 7 +
 rtl/quant_writeback.sv | 104 ++++++++++
 tb/tb_quant_writeback.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/smac_wb_pkg.sv
// smac_wb_pkg: shared write-back FSM states and default burst geometry
package smac_wb_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, CLEAR} wb_state_t;
  localparam int WB_N_WORDS = 16;
  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 10;
endpackage

// File: rtl/quant_writeback.sv
// quant_writeback: streams quantized words from the result buffer to memory, then clears the done flag
// Optional build macro WB_PARITY_EN appends an even-parity bit as the MSB of mem_wdata.
module quant_writeback
  import smac_wb_pkg::*;
#(
  parameter int N_WORDS = WB_N_WORDS,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
`ifdef WB_PARITY_EN
  localparam int WD_W = DATA_W + 1
`else
  localparam int WD_W = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              quant_done_flag,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WD_W-1:0]   mem_wdata,
  input  logic              mem_ready,
  output logic              clear,
  output logic              busy
);
  wb_state_t state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n, rd_idx_n;
  logic [ADDR_W-1:0] base, base_n, mem_addr_n;
  logic [WD_W-1:0] mem_wdata_n;
  logic rd_en_n, mem_we_n, clear_n;
  logic last;
  assign last = cnt == IDX_W'(N_WORDS - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      rd_en <= 1'b0;
      rd_idx <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      clear <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      base <= base_n;
      rd_en <= rd_en_n;
      rd_idx <= rd_idx_n;
      mem_we <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      clear <= clear_n;
      busy <= state_n != IDLE;
    end
  end
  // Outputs are computed for the state being entered so they are registered yet aligned with it.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    base_n = base;
    rd_en_n = 1'b0;
    rd_idx_n = rd_idx;
    mem_we_n = mem_we;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    clear_n = 1'b0;
    case (state)
      IDLE: if (quant_done_flag) begin
        base_n = base_addr;
        cnt_n = '0;
        rd_en_n = 1'b1;
        rd_idx_n = '0;
        state_n = FETCH;
      end
      FETCH: state_n = CAPTURE;
      CAPTURE: begin
`ifdef WB_PARITY_EN
        mem_wdata_n = {^rd_data, rd_data};
`else
        mem_wdata_n = rd_data;
`endif
        mem_addr_n = base + ADDR_W'(cnt);
        mem_we_n = 1'b1;
        state_n = WRITE;
      end
      WRITE: if (mem_ready) begin
        mem_we_n = 1'b0;
        state_n = last ? CLEAR : FETCH;
        clear_n = last;
        rd_en_n = !last;
        cnt_n = last ? cnt : cnt + 1'b1;
        rd_idx_n = last ? rd_idx : cnt + 1'b1;
      end
      CLEAR: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_quant_writeback.sv
// tb_quant_writeback: randomized write-back bursts checked against a queue of expected memory writes
module tb_quant_writeback;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int AW = 10;
`ifdef WB_PARITY_EN
  localparam int WD = DW + 1;
`else
  localparam int WD = DW;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flag = 1'b0;
  logic mem_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] rd_data = '0;
  logic rd_en, mem_we, clear, busy;
  logic [1:0] rd_idx;
  logic [AW-1:0] mem_addr;
  logic [WD-1:0] mem_wdata;
  always #5 clk = ~clk;
  quant_writeback #(.N_WORDS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .quant_done_flag(flag), .base_addr(base_addr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .clear(clear), .busy(busy)
  );
  int n_vec = 0, n_err = 0;
  int cyc = 0, first_fetch = 0, fetch_exp = 0, stalls = 0, clears = 0;
  logic [DW-1:0] bufm [N];
  logic [AW+WD-1:0] expq [$];
  function automatic logic [WD-1:0] enc(logic [DW-1:0] d);
`ifdef WB_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_idx"}, rd_idx, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  // One clock: buffer model, write scoreboard, stall stability and clear timing.
  task automatic step();
    logic we, rdy, clr, ren;
    logic [1:0] ridx;
    logic [AW-1:0] a;
    logic [WD-1:0] d;
    logic [AW+WD-1:0] e;
    we = mem_we; rdy = mem_ready; clr = clear; ren = rd_en; ridx = rd_idx;
    a = mem_addr; d = mem_wdata;
    @(posedge clk);
    #1;
    cyc++;
    if (ren) rd_data = bufm[ridx];
    if (we && rdy) begin
      chk("write_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("wr_addr", a, e[AW+WD-1:WD]);
        chk("wr_data", d, e[WD-1:0]);
      end
    end
    if (we && !rdy) begin
      stalls++;
      chk("stall_we", mem_we, 1);
      chk("stall_addr", mem_addr, a);
      chk("stall_data", mem_wdata, d);
    end
    if (rd_en) begin
      chk("rd_idx", rd_idx, fetch_exp);
      if (fetch_exp == 0) first_fetch = cyc;
      fetch_exp++;
    end
    if (clr) begin
      flag = 1'b0;
      chk("clear_one_cycle", clear, 0);
    end
    if (clear) begin
      clears++;
      chk("clear_latency", cyc - first_fetch, 3 * N + stalls);
      chk("writes_left", expq.size(), 0);
      chk("busy_with_clear", busy, 1);
    end
  endtask
  task automatic prep(logic [AW-1:0] base);
    expq.delete();
    for (int i = 0; i < N; i++) expq.push_back({AW'(base + AW'(i)), enc(bufm[i])});
    fetch_exp = 0; stalls = 0; clears = 0;
    base_addr = base;
  endtask
  task automatic run(int pct, int stall_word, bit drop);
    int held;
    held = 0;
    flag = 1'b1;
    mem_ready = $urandom_range(1);
    step();
    chk("first_fetch", rd_en, 1);
    for (int k = 0; k < 300 && clears == 0; k++) begin
      if (stall_word >= 0 && fetch_exp == stall_word + 1 && mem_we && held < 5) begin
        mem_ready = 1'b0;
        held++;
      end else mem_ready = $urandom_range(99) < pct;
      base_addr = AW'($urandom);
      if (drop && k == 5) flag = 1'b0;
      step();
    end
    chk("clear_seen", clears, 1);
    mem_ready = $urandom_range(1);
    step();
    chk("busy_after", busy, 0);
    chk("idle_no_we", mem_we, 0);
    step();
    chk("no_retrigger", rd_en, 0);
  endtask
  initial begin
    for (int i = 0; i < N; i++) bufm[i] = DW'(8'hA0 + i);
    prep(10'h010);
    flag = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_zero("reset");
    end
    rst_n = 1'b1;
    run(100, -1, 0);
    for (int i = 0; i < N; i++) bufm[i] = DW'($urandom);
    prep(10'h155);
    run(100, 2, 0);
    chk("backpressure_stalls", stalls, 5);
    for (int i = 0; i < N; i++) bufm[i] = DW'($urandom);
    prep(10'h3FE);
    run(100, -1, 0);
    bufm[0] = 8'h07; bufm[1] = 8'h03; bufm[2] = 8'hFF; bufm[3] = 8'h00;
    prep(10'h200);
    run(70, -1, 1);
    chk("parity_07", enc(8'h07), {1'b0, enc(8'h07)} & {1'b0, (WD == DW + 1) ? 9'h107 : 9'h007});
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < N; i++) bufm[i] = DW'($urandom);
      prep(AW'($urandom));
      run(50, -1, b[0]);
    end
    for (int i = 0; i < N; i++) bufm[i] = DW'($urandom);
    prep(10'h0C0);
    flag = 1'b1;
    mem_ready = 1'b0;
    for (int k = 0; k < 100 && !(fetch_exp == 3 && mem_we); k++) step();
    chk("reached_word2_write", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    for (int i = 0; i < 2; i++) begin
      step();
      chk_zero("midreset_hold");
    end
    chk("midreset_no_clear", clears, 0);
    for (int i = 0; i < N; i++) bufm[i] = DW'($urandom);
    prep(10'h0C8);
    rst_n = 1'b1;
    run(100, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
